// File: rtl/reg_file_sb.sv
// Register file with scoreboard: two combinational read ports with optional writeback bypass,
// one writeback port, and one pending-write bit per register with a registered popcount.
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] add_1,
    input  logic [ADDR_W-1:0] add_2,
    output logic [DATA_W-1:0] r_data_1,
    output logic [DATA_W-1:0] r_data_2,
    output logic              busy_1,
    output logic              busy_2,
    input  logic [ADDR_W-1:0] add_3,
    input  logic [DATA_W-1:0] write_data,
    input  logic              REG_WRITE_W,
    input  logic [ADDR_W-1:0] issue_add,
    input  logic              ISSUE_EN,
    output logic [ADDR_W:0]   pend_cnt
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] rf [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic [DEPTH-1:0]  set_vec;
    logic [DEPTH-1:0]  clr_vec;
    logic              wr_ok;
    logic              iss_ok;
    logic              cnt_inc;
    logic              cnt_dec;

    // Register 0 is hard-wired when ZERO_REG is set: it never takes a write or an issue.
    assign wr_ok  = REG_WRITE_W && !((ZERO_REG != 0) && (add_3 == '0));
    assign iss_ok = ISSUE_EN && !((ZERO_REG != 0) && (issue_add == '0));

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_pend
            assign set_vec[gi] = iss_ok && (issue_add == ADDR_W'(gi));
            assign clr_vec[gi] = wr_ok && (add_3 == ADDR_W'(gi));
        end
    endgenerate

    // Count only real transitions; a set on the register being cleared keeps it pending.
    assign cnt_inc = iss_ok && !pend[issue_add];
    assign cnt_dec = wr_ok && pend[add_3] && !(iss_ok && (issue_add == add_3));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf[i] <= '0;
            end
        end else if (wr_ok) begin
            rf[add_3] <= write_data;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            pend     <= (pend & ~clr_vec) | set_vec;
            pend_cnt <= pend_cnt + {{ADDR_W{1'b0}}, cnt_inc} - {{ADDR_W{1'b0}}, cnt_dec};
        end
    end

    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];
    logic              rd_busy [2];

    assign rd_addr[0] = add_1;
    assign rd_addr[1] = add_2;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic is_zero;
            logic fwd;
            assign is_zero     = (ZERO_REG != 0) && (rd_addr[gi] == '0);
            assign fwd         = (BYPASS != 0) && wr_ok && (add_3 == rd_addr[gi]);
            assign rd_data[gi] = is_zero ? '0 : (fwd ? write_data : rf[rd_addr[gi]]);
            assign rd_busy[gi] = !is_zero && pend[rd_addr[gi]] && !fwd;
        end
    endgenerate

    assign r_data_1 = rd_data[0];
    assign r_data_2 = rd_data[1];
    assign busy_1   = rd_busy[0];
    assign busy_2   = rd_busy[1];
endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus random traffic against an
// array-based model; a BYPASS=0 instance shares all inputs with the default instance.
module tb_reg_file_sb;
    logic        CLK = 1'b0;
    logic        RST_N;
    logic [4:0]  add_1, add_2, add_3, issue_add;
    logic [31:0] write_data;
    logic        REG_WRITE_W, ISSUE_EN;
    logic [31:0] r_data_1, r_data_2, r_data_1_nb, r_data_2_nb;
    logic        busy_1, busy_2, busy_1_nb, busy_2_nb;
    logic [5:0]  pend_cnt, pend_cnt_nb;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_rf [32];
    bit          m_pend [32];

    always #5 CLK = ~CLK;

    reg_file_sb dut (
        .CLK(CLK), .RST_N(RST_N), .add_1(add_1), .add_2(add_2),
        .r_data_1(r_data_1), .r_data_2(r_data_2), .busy_1(busy_1), .busy_2(busy_2),
        .add_3(add_3), .write_data(write_data), .REG_WRITE_W(REG_WRITE_W),
        .issue_add(issue_add), .ISSUE_EN(ISSUE_EN), .pend_cnt(pend_cnt)
    );

    reg_file_sb #(.BYPASS(0)) dut_nb (
        .CLK(CLK), .RST_N(RST_N), .add_1(add_1), .add_2(add_2),
        .r_data_1(r_data_1_nb), .r_data_2(r_data_2_nb), .busy_1(busy_1_nb), .busy_2(busy_2_nb),
        .add_3(add_3), .write_data(write_data), .REG_WRITE_W(REG_WRITE_W),
        .issue_add(issue_add), .ISSUE_EN(ISSUE_EN), .pend_cnt(pend_cnt_nb)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int popcount();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_pend[i]);
        return n;
    endfunction

    // Architectural view: a write to a nonzero register is visible this cycle only with bypass.
    function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        if (byp && REG_WRITE_W && add_3 == a) return write_data;
        return m_rf[a];
    endfunction

    function automatic logic [31:0] exp_busy(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        if (byp && REG_WRITE_W && add_3 == a) return 32'd0;
        return {31'd0, m_pend[a]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_rf[i]   = 32'd0;
            m_pend[i] = 1'b0;
        end
    endtask

    task automatic check_ports(input string tag);
        check({tag, ".rd1"},    r_data_1,           exp_data(add_1, 1'b1));
        check({tag, ".rd2"},    r_data_2,           exp_data(add_2, 1'b1));
        check({tag, ".bz1"},    {31'd0, busy_1},    exp_busy(add_1, 1'b1));
        check({tag, ".bz2"},    {31'd0, busy_2},    exp_busy(add_2, 1'b1));
        check({tag, ".nb.rd1"}, r_data_1_nb,        exp_data(add_1, 1'b0));
        check({tag, ".nb.rd2"}, r_data_2_nb,        exp_data(add_2, 1'b0));
        check({tag, ".nb.bz1"}, {31'd0, busy_1_nb}, exp_busy(add_1, 1'b0));
        check({tag, ".nb.bz2"}, {31'd0, busy_2_nb}, exp_busy(add_2, 1'b0));
    endtask

    task automatic check_cnt(input string tag);
        check({tag, ".cnt"},    {26'd0, pend_cnt},    32'(popcount()));
        check({tag, ".nb.cnt"}, {26'd0, pend_cnt_nb}, 32'(popcount()));
    endtask

    // Apply the current inputs to the model, take one clock edge, settle.
    task automatic tick();
        if (REG_WRITE_W && add_3 != 5'd0) begin
            m_rf[add_3]   = write_data;
            m_pend[add_3] = 1'b0;
        end
        if (ISSUE_EN && issue_add != 5'd0) m_pend[issue_add] = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        REG_WRITE_W = 1'b0;
        ISSUE_EN    = 1'b0;
        add_3       = 5'd0;
        issue_add   = 5'd0;
        write_data  = 32'd0;
    endtask

    task automatic apply_reset();
        RST_N = 1'b0;
        model_reset();
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        #1;
    endtask

    initial begin
        idle();
        add_1 = 5'd5;
        add_2 = 5'd9;
        RST_N = 1'b1;
        #2;
        apply_reset();
        check_ports("reset");
        check_cnt("reset");

        // Bypass write to r5
        add_3 = 5'd5; write_data = 32'hDEADBEEF; REG_WRITE_W = 1'b1; add_1 = 5'd5;
        #1;
        check("byp.same", r_data_1, 32'hDEADBEEF);
        check("nobyp.same", r_data_1_nb, 32'd0);
        tick();
        idle();
        #1;
        check("byp.next", r_data_1, 32'hDEADBEEF);
        check("nobyp.next", r_data_1_nb, 32'hDEADBEEF);
        $display("txn write r5 0xDEADBEEF");

        // Register zero never written, never pending
        add_3 = 5'd0; write_data = 32'h1234; REG_WRITE_W = 1'b1; add_1 = 5'd0;
        #1;
        check_ports("r0.wr");
        tick();
        idle();
        issue_add = 5'd0; ISSUE_EN = 1'b1;
        #1;
        check("r0.rd", r_data_1, 32'd0);
        check("r0.busy", {31'd0, busy_1}, 32'd0);
        tick();
        idle();
        check("r0.cnt", {26'd0, pend_cnt}, 32'd0);
        $display("txn r0 write/issue ignored");

        // Issue r7 then write it back
        issue_add = 5'd7; ISSUE_EN = 1'b1;
        tick();
        idle();
        add_1 = 5'd7;
        #1;
        check("r7.busy", {31'd0, busy_1}, 32'd1);
        check("r7.cnt", {26'd0, pend_cnt}, 32'd1);
        add_3 = 5'd7; write_data = 32'h55; REG_WRITE_W = 1'b1;
        #1;
        check("r7.wb.busy", {31'd0, busy_1}, 32'd0);
        check("r7.wb.data", r_data_1, 32'h55);
        check("r7.wb.nbbusy", {31'd0, busy_1_nb}, 32'd1);
        tick();
        idle();
        check("r7.cnt0", {26'd0, pend_cnt}, 32'd0);
        $display("txn issue/writeback r7");

        // Issue and writeback the same pending register: set wins
        issue_add = 5'd9; ISSUE_EN = 1'b1;
        tick();
        add_3 = 5'd9; write_data = 32'h99; REG_WRITE_W = 1'b1; add_1 = 5'd9;
        tick();
        idle();
        #1;
        check("r9.busy", {31'd0, busy_1}, 32'd1);
        check("r9.data", r_data_1, 32'h99);
        check("r9.cnt", {26'd0, pend_cnt}, 32'd1);
        issue_add = 5'd4; ISSUE_EN = 1'b1;
        tick();
        issue_add = 5'd3; add_3 = 5'd4; write_data = 32'h44; REG_WRITE_W = 1'b1;
        tick();
        idle();
        check("r3r4.cnt", {26'd0, pend_cnt}, 32'd2);
        check_ports("r3r4");
        $display("txn set-wins r9, issue r3 + wb r4");

        // Fill the scoreboard
        apply_reset();
        for (int i = 1; i < 32; i++) begin
            issue_add = 5'(i); ISSUE_EN = 1'b1;
            tick();
        end
        check("fill.cnt", {26'd0, pend_cnt}, 32'd31);
        issue_add = 5'd1;
        tick();
        idle();
        check("fill.reissue", {26'd0, pend_cnt}, 32'd31);
        check_cnt("fill");
        $display("txn fill r1..r31 pend_cnt=%0d", pend_cnt);

        // Random traffic
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            add_3       = 5'($urandom_range(0, 31));
            issue_add   = ($urandom_range(0, 3) == 0) ? add_3 : 5'($urandom_range(0, 31));
            add_1       = ($urandom_range(0, 2) == 0) ? add_3 : 5'($urandom_range(0, 31));
            add_2       = 5'($urandom_range(0, 31));
            write_data  = $urandom;
            REG_WRITE_W = ($urandom_range(0, 1) == 1);
            ISSUE_EN    = ($urandom_range(0, 2) != 0);
            #1;
            check_ports("rand");
            tick();
            check_cnt("rand");
            if (n % 50 == 0)
                $display("txn rand %0d wr=%0d a3=%0d iss=%0d ia=%0d cnt=%0d",
                         n, REG_WRITE_W, add_3, ISSUE_EN, issue_add, pend_cnt);
        end
        idle();

        // Asynchronous reset mid-cycle
        apply_reset();
        add_3 = 5'd2; write_data = 32'hA; REG_WRITE_W = 1'b1;
        tick();
        idle();
        for (int i = 10; i < 14; i++) begin
            issue_add = 5'(i); ISSUE_EN = 1'b1;
            tick();
        end
        idle();
        add_1 = 5'd2; add_2 = 5'd10;
        #1;
        check("arst.pre.cnt", {26'd0, pend_cnt}, 32'd4);
        check("arst.pre.rd", r_data_1, 32'hA);
        #1;
        RST_N = 1'b0;
        model_reset();
        #1;
        check("arst.cnt", {26'd0, pend_cnt}, 32'd0);
        check("arst.rd", r_data_1, 32'd0);
        check("arst.busy", {31'd0, busy_2}, 32'd0);
        // Activity held across edges while in reset must be discarded
        issue_add = 5'd6; ISSUE_EN = 1'b1; add_3 = 5'd8; write_data = 32'hBAD; REG_WRITE_W = 1'b1;
        @(posedge CLK);
        #1;
        idle();
        RST_N = 1'b1;
        add_1 = 5'd8; add_2 = 5'd6;
        #1;
        check_ports("arst.post");
        check_cnt("arst.post");
        $display("txn async reset mid-cycle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
